// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: latches two operands, adds them LSB-first through
// an internal one-bit slice with a carry flop, and presents the parallel result.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] s_ins;
    logic [WIDTH-1:0] s_shifted;

    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (x & ci) | (y & ci);
    endfunction

    // One-bit adder slice on the current LSBs
    assign s_bit = fa_sum(a_sh_q[0], b_sh_q[0], carry_q);
    assign c_bit = fa_carry(a_sh_q[0], b_sh_q[0], carry_q);

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case
    always_comb begin
        s_ins            = '0;
        s_ins[WIDTH-1]   = s_bit;
        s_shifted        = (s_sh_q >> 1) | s_ins;
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                carry_d = c_bit;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                s_sh_d  = s_shifted;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    sum_d   = s_shifted;
                    cout_d  = c_bit;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == SHIFT) || (state_q == DONE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: an 8-bit and a 1-bit instance, each tracked by an
// operation-level model, plus directed operations with literal expectations.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .a_in(a1), .b_in(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Operation-level model: an accepted add completes WIDTH edges later with
    // (a+b) split into a WIDTH-bit sum and the overflow bit.
    longint edge_n = 0;
    bit     chk_en = 0;
    int     mw[2] = '{8, 1};
    bit     m_active[2];
    longint m_done_edge[2];
    longint m_sum[2], m_nsum[2];
    bit     m_cout[2], m_ncout[2], m_done[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit st;
            longint a, b, t;
            st = (i == 0) ? start8 : start1;
            a  = (i == 0) ? longint'(a8) : longint'(a1);
            b  = (i == 0) ? longint'(b8) : longint'(b1);
            m_done[i] = 0;
            if (reset) begin
                m_active[i] = 0;
                m_sum[i] = 0;
                m_cout[i] = 0;
            end else if (m_active[i]) begin
                if (edge_n == m_done_edge[i]) begin
                    m_sum[i]  = m_nsum[i];
                    m_cout[i] = m_ncout[i];
                    m_done[i] = 1;
                end else if (edge_n == m_done_edge[i] + 1) begin
                    m_active[i] = 0;
                end
            end else if (st) begin
                t = a + b;
                m_nsum[i]      = t % (longint'(1) << mw[i]);
                m_ncout[i]     = t[mw[i]];
                m_done_edge[i] = edge_n + mw[i];
                m_active[i]    = 1;
            end
        end
        if (reset) chk_en = 1;
        edge_n++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy8", busy8, m_active[0]);
            check("done8", done8, m_done[0]);
            check("sum8",  sum8,  m_sum[0]);
            check("cout8", cout8, m_cout[0]);
            check("busy1", busy1, m_active[1]);
            check("done1", done1, m_done[1]);
            check("sum1",  sum1,  m_sum[1]);
            check("cout1", cout1, m_cout[1]);
        end
    end

    // One add on the 8-bit instance with literal result and latency checks.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input int es, input int ec, input string nm);
        int cnt;
        bit seen;
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        cnt = 0; seen = 0;
        while (!seen && cnt < 20) begin
            @(negedge clk);
            start8 = 1'b0;
            cnt++;
            if (cnt == 1) check({nm, "_busy_next"}, busy8, 1);
            if (done8) seen = 1;
        end
        check({nm, "_latency"}, seen ? cnt : -1, 9);
        check({nm, "_sum"}, sum8, es);
        check({nm, "_cout"}, cout8, ec);
        @(negedge clk);
        check({nm, "_done_low"}, done8, 0);
    endtask

    task automatic op1(input logic a, input logic b, input string nm);
        int cnt;
        bit seen;
        @(negedge clk);
        a1 = a; b1 = b; start1 = 1'b1;
        cnt = 0; seen = 0;
        while (!seen && cnt < 10) begin
            @(negedge clk);
            start1 = 1'b0;
            cnt++;
            if (done1) seen = 1;
        end
        check({nm, "_latency"}, seen ? cnt : -1, 2);
        check({nm, "_sum"}, sum1, a ^ b);
        check({nm, "_cout"}, cout1, a & b);
        @(negedge clk);
    endtask

    initial begin
        int last, pulses, cnt;
        bit seen;

        repeat (2) @(negedge clk);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_sum8", sum8, 0);
        check("rst_cout8", cout8, 0);
        reset = 1'b0;

        op8(8'd3,   8'd5,   8,   0, "add3_5");
        op8(8'd255, 8'd1,   0,   1, "add255_1");
        op8(8'd255, 8'd255, 254, 1, "add255_255");
        op8(8'd0,   8'd0,   0,   0, "add0_0");

        // Start held high: back-to-back adds every WIDTH+2 cycles
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        last = -1; pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done8) begin
                pulses++;
                if (last >= 0) check("held_spacing", i - last, 10);
                check("held_sum", sum8, 8'hFF);
                check("held_cout", cout8, 0);
                last = i;
            end
        end
        check("held_pulses", pulses, 3);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // Start pulse during SHIFT is ignored
        a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
        cnt = 0; seen = 0;
        while (!seen && cnt < 20) begin
            @(negedge clk);
            cnt++;
            start8 = (cnt == 3);
            if (cnt == 3) begin a8 = 8'd100; b8 = 8'd100; end
            if (done8) seen = 1;
        end
        start8 = 1'b0;
        check("ign_latency", seen ? cnt : -1, 9);
        check("ign_sum", sum8, 2);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        check("ign_no_second_done", pulses, 0);

        // Reset in the middle of SHIFT
        a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_done", done8, 0);
        check("mid_rst_sum", sum8, 0);
        check("mid_rst_cout", cout8, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        check("mid_rst_no_done", pulses, 0);
        op8(8'd200, 8'd100, 44, 1, "add200_100");

        // WIDTH=1 instance, all operand pairs
        op1(1'b0, 1'b0, "w1_00");
        op1(1'b0, 1'b1, "w1_01");
        op1(1'b1, 1'b0, "w1_10");
        op1(1'b1, 1'b1, "w1_11");
        op1(1'b0, 1'b0, "w1_00b");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencing controller for the team's bit-serial adder datapath. It accepts two parallel WIDTH-bit operands on a start handshake and shifts them LSB-first through a one-bit adder slice that holds a carry state. It collects the serial sum bits into a parallel result and reports completion and carry-out. It sits between a parallel requester (register file / test harness) and the serial adder slice. The slice and its carry flip-flop are internal to this block.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
a_in  input  WIDTH  operand A; captured on the accepted start.
b_in  input  WIDTH  operand B; captured on the accepted start.
busy  output  1  high in SHIFT and DONE.
done  output  1  one-cycle pulse; result valid.
sum  output  WIDTH  registered result; (a+b) mod 2^WIDTH.
cout  output  1  registered final carry.

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, bit counter=0, operand/sum shift registers=0. Reset has priority over every other input.
- States: IDLE, SHIFT, DONE. Encoding is free; unreachable encodings go to IDLE.
- IDLE, start=1 at edge k:
  - a_in and b_in are latched into shift registers a_sh and b_sh.
  - carry is cleared to 0 and the counter is cleared to 0.
  - The state moves to SHIFT.
- IDLE, start=0: the block stays in IDLE; sum and cout hold their values.
- SHIFT, combinational per cycle:
  - s = a_sh[0] ^ b_sh[0] ^ carry.
  - c_next = majority(a_sh[0], b_sh[0], carry).
- SHIFT, at each edge:
  - carry <= c_next.
  - a_sh and b_sh shift right by 1, filling with 0.
  - s_sh shifts right with s entering at the MSB.
  - The counter increments.
- Exit from SHIFT: after the WIDTH-th SHIFT edge (counter == WIDTH-1 at that edge) the state moves to DONE. On that same edge, sum <= {s, s_sh[WIDTH-1:1]} and cout <= c_next.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - The next edge returns to IDLE unconditionally.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+WIDTH. sum and cout are valid from that cycle on.
- Throughput: one add per WIDTH+2 cycles with back-to-back starts.
- sum and cout change only on the completion edge and on reset. The previous result is held through IDLE and through the next SHIFT phase.
- start while busy (SHIFT or DONE) is ignored and is not queued. A start held high continuously is accepted on the first IDLE cycle after DONE.
- a_in and b_in are don't-care except on the accepted start edge; changes during SHIFT have no effect.
- Reset mid-operation (SHIFT or DONE): the block returns to IDLE next edge, done is not pulsed, and sum/cout are cleared to 0.
- Width rule: overflow beyond WIDTH appears only on cout; there is no sign handling (unsigned add).
- WIDTH=1: SHIFT lasts exactly one cycle. sum = a^b and cout = a&b.
- Carry state is always cleared at the start of an operation, so no carry leaks between consecutive operations.

Test Plan:
- WIDTH=8, reset 2 cycles then start with a=3, b=5 -> busy high from the next cycle; done pulses 9 cycles after the start edge; sum=8, cout=0; done low the following cycle.
- a=255, b=1 -> sum=0, cout=1. Then a=255, b=255 -> sum=254, cout=1. Then a=0, b=0 -> sum=0, cout=0, confirming the carry from the previous op is cleared.
- a=0xAA, b=0x55 with start held high continuously for 30 cycles -> sum=0xFF, cout=0 each op. done pulses spaced exactly 10 cycles apart; sum/cout stable between pulses.
- start=1 with a=1, b=1; then during SHIFT pulse start with a=100, b=100 -> that pulse is ignored; sum=2 at done; no second done until a new start in IDLE.
- Start a=200, b=100; assert reset on the 4th SHIFT cycle for one cycle -> state IDLE, busy=0, no done pulse, sum=0, cout=0. A subsequent add of 200+100 completes with sum=44, cout=1.
- WIDTH=1 build, exhaustive a,b in {0,1} -> done 2 cycles after the start edge; sum=a^b, cout=a&b.
